unary_host_13: RTL

Initiator for the 13-bit unary adder. Accepts two binary operands over a valid/ready handshake and serializes them as unary pulse trains on `A`/`B` during the adder's read phase. It then switches the adder to its write phase, counts the returned `dout` pulses back into binary, and captures the adder's overflow flag. It sits between binary-domain logic and one unary adder instance, and is the only driver of that adder's `en` and `read_or_write` inputs.

---
 rtl/unary_pkg.sv | 11 +
 rtl/unary_host_13_if.sv | 31 +++
 rtl/unary_pulse_gen.sv | 38 +++
 rtl/unary_host_13.sv | 139 +++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
// Shared width and host state set for the 13-bit unary adder and its host.
package unary_pkg;
  localparam int UNARY_W = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } host_state_t;
endpackage

// File: rtl/unary_host_13_if.sv
// Bundle of the operand, adder-side and result signals of the unary adder host.
interface unary_host_13_if
  import unary_pkg::*;
#(
  parameter int W = UNARY_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         A;
  logic         B;
  logic         en;
  logic         read_or_write;
  logic         dout;
  logic         C;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_carry;

  modport master (
    input  in_valid, in_a, in_b, dout, C, res_ready,
    output in_ready, A, B, en, read_or_write, res_valid, res_sum, res_carry
  );

  modport slave (
    output in_valid, in_a, in_b, dout, C, res_ready,
    input  in_ready, A, B, en, read_or_write, res_valid, res_sum, res_carry
  );
endinterface

// File: rtl/unary_pulse_gen.sv
// Front-loaded unary pulse source: loaded with a length, emits one high beat per step
// until the remaining count reaches zero.
module unary_pulse_gen
  import unary_pkg::*;
#(
  parameter int W = UNARY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] len,
  input  logic         step,
  output logic         active
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] rem_r;
  logic         active_r;

  // Remaining-count register; active_r mirrors (rem_r != 0) so the pulse leaves a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_r    <= '0;
      active_r <= 1'b0;
    end else if (load) begin
      rem_r    <= len;
      active_r <= (len != '0);
    end else if (step && active_r) begin
      rem_r    <= rem_r - ONE;
      active_r <= (rem_r != ONE);
    end else begin
      rem_r    <= rem_r;
      active_r <= active_r;
    end
  end

  assign active = active_r;
endmodule

// File: rtl/unary_host_13.sv
// Binary-to-unary initiator for one 13-bit unary adder: emits operands as pulse
// trains, drains the adder's unary result back into binary and captures overflow.
module unary_host_13
  import unary_pkg::*;
#(
  parameter int W = UNARY_W
) (
  input  logic            clk,
  input  logic            rst_n,
  unary_host_13_if.master bus
);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_EMIT  = EMIT;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [1:0]   state_r;
  logic [W-1:0] n_r;
  logic [W-1:0] beat_r;
  logic [W-1:0] sum_r;
  logic         carry_r;
  logic         first_drain_r;
  logic         in_ready_r;
  logic         en_r;
  logic         rw_r;
  logic         res_valid_r;
  logic [W-1:0] max_s;
  logic         accept_s;
  logic         emit_s;
  logic         a_s;
  logic         b_s;

  assign accept_s = (state_r == ST_IDLE) && bus.in_valid;
  assign emit_s   = (state_r == ST_EMIT);

  // Beat count of the read phase is the larger operand.
  always_comb begin
    if (bus.in_a > bus.in_b) begin
      max_s = bus.in_a;
    end else begin
      max_s = bus.in_b;
    end
  end

  unary_pulse_gen #(.W(W)) u_gen_a (
    .clk(clk), .rst_n(rst_n), .load(accept_s), .len(bus.in_a), .step(emit_s), .active(a_s)
  );

  unary_pulse_gen #(.W(W)) u_gen_b (
    .clk(clk), .rst_n(rst_n), .load(accept_s), .len(bus.in_b), .step(emit_s), .active(b_s)
  );

  // Host FSM with beat/sum counters, sticky carry and handshake registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      n_r           <= '0;
      beat_r        <= '0;
      sum_r         <= '0;
      carry_r       <= 1'b0;
      first_drain_r <= 1'b0;
      in_ready_r    <= 1'b1;
      en_r          <= 1'b0;
      rw_r          <= 1'b0;
      res_valid_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            n_r           <= max_s;
            beat_r        <= '0;
            sum_r         <= '0;
            carry_r       <= 1'b0;
            in_ready_r    <= 1'b0;
            en_r          <= 1'b1;
            first_drain_r <= (max_s == '0);
            if (max_s != '0) begin
              state_r <= ST_EMIT;
              rw_r    <= 1'b0;
            end else begin
              state_r <= ST_DRAIN;
              rw_r    <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          beat_r <= beat_r + ONE;
          // C on the first beat is stale; an overflow on beat i shows up at beat i+1.
          if (beat_r != '0) begin
            carry_r <= carry_r | bus.C;
          end
          if (beat_r == n_r - ONE) begin
            state_r       <= ST_DRAIN;
            rw_r          <= 1'b1;
            first_drain_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // First drain cycle still carries the last read beat's C, and dout lags by one.
          if (first_drain_r) begin
            first_drain_r <= 1'b0;
            carry_r       <= carry_r | bus.C;
          end else if (bus.dout) begin
            sum_r <= sum_r + ONE;
          end else begin
            state_r     <= ST_DONE;
            en_r        <= 1'b0;
            rw_r        <= 1'b0;
            res_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            state_r     <= ST_IDLE;
            res_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          en_r        <= 1'b0;
          rw_r        <= 1'b0;
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_r;
  assign bus.A             = a_s;
  assign bus.B             = b_s;
  assign bus.en            = en_r;
  assign bus.read_or_write = rw_r;
  assign bus.res_valid     = res_valid_r;
  assign bus.res_sum       = sum_r;
  assign bus.res_carry     = carry_r;
endmodule
